// File: rtl/out_port_fifo_if.sv
// Device-side handshake of the CPU output port FIFO.
// Macro OUT_PORT_PARITY_EN adds the dev_parity signal.
interface out_port_fifo_if #(
  parameter int DATA_W = 32
);
  logic              dev_ready;
  logic              dev_valid;
  logic [DATA_W-1:0] dev_data;
`ifdef OUT_PORT_PARITY_EN
  logic              dev_parity;
`endif

`ifdef OUT_PORT_PARITY_EN
  modport master (
    input  dev_ready,
    output dev_valid,
    output dev_data,
    output dev_parity
  );
  modport slave (
    output dev_ready,
    input  dev_valid,
    input  dev_data,
    input  dev_parity
  );
`else
  modport master (
    input  dev_ready,
    output dev_valid,
    output dev_data
  );
  modport slave (
    output dev_ready,
    input  dev_valid,
    input  dev_data
  );
`endif
endinterface

// File: rtl/out_port_fifo.sv
// Output port FIFO: captures bus words on OutPortenable, drains over valid/ready.
// Macro OUT_PORT_PARITY_EN stores and presents even parity of each word.
module out_port_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              OutPortenable,
  input  logic [DATA_W-1:0] BusMuxOut,
  out_port_fifo_if.master   dev,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef OUT_PORT_PARITY_EN
  logic              mem_par [DEPTH];
`endif

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              valid;
  logic              push;
  logic              pop;
  logic              drop;

  assign valid = (state_q == HOLD);
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = valid & dev.dev_ready;
  // A pop on the same edge frees the slot a full FIFO needs.
  assign push  = OutPortenable & (~full | pop);
  assign drop  = OutPortenable & full & ~pop;

  assign dev.dev_valid = valid;
  assign dev.dev_data  = valid ? mem[rd_ptr] : '0;
`ifdef OUT_PORT_PARITY_EN
  assign dev.dev_parity = valid ? mem_par[rd_ptr] : 1'b0;
`endif

  // Drain state register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Drain next state: leave HOLD only when the last word pops unreplaced.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (push) state_d = HOLD;
      HOLD: if (pop && !push && count == ONE_CNT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      unique case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage is never visible before it is written, so it has no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= BusMuxOut;
`ifdef OUT_PORT_PARITY_EN
      mem_par[wr_ptr] <= ^BusMuxOut;
`endif
    end
  end

endmodule

// File: tb/tb_out_port_fifo.sv
// Scoreboard bench for out_port_fifo: random and directed pushes/drains
// checked against a queue model of the FIFO.
module tb_out_port_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          OutPortenable = 1'b0;
  logic [DW-1:0] BusMuxOut = '0;
  logic          full;
  logic          empty;
  logic          overflow;
  logic [AW:0]   count;

  out_port_fifo_if #(.DATA_W(DW)) dev_if ();

  out_port_fifo #(
    .DATA_W(DW),
    .DEPTH (DEPTH),
    .ADDR_W(AW)
  ) dut (
    .clock        (clock),
    .clear        (clear),
    .OutPortenable(OutPortenable),
    .BusMuxOut    (BusMuxOut),
    .dev          (dev_if),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] exp_q [$];
  int            mdl_cnt = 0;
  int            mdl_next = 0;
  bit            mdl_ovf = 0;
  bit            mdl_ovf_next = 0;
  bit            in_reset = 1;
  bit            prev_hold = 0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One cycle of stimulus; the model decides what the next edge must do.
  task automatic step(input bit en, input logic [DW-1:0] d, input bit rdy);
    bit mpop;
    bit acc;
    @(posedge clock);
    #1;
    mdl_cnt = mdl_next;
    mdl_ovf = mdl_ovf_next;
    OutPortenable = en;
    BusMuxOut = d;
    dev_if.dev_ready = rdy;
    mpop = (mdl_cnt > 0) && rdy;
    acc = en && ((mdl_cnt < DEPTH) || mpop);
    if (acc) exp_q.push_back(d);
    if (en && !acc) mdl_ovf_next = 1;
    mdl_next = mdl_cnt + int'(acc) - int'(mpop);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2;
    in_reset = 1;
    clear = 1'b0;
    #1;
    chk("rst_valid", 64'(dev_if.dev_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_data", 64'(dev_if.dev_data), 64'd0);
    exp_q.delete();
    mdl_cnt = 0;
    mdl_next = 0;
    mdl_ovf = 0;
    mdl_ovf_next = 0;
    OutPortenable = 1'b0;
    BusMuxOut = '0;
    dev_if.dev_ready = 1'b0;
    @(negedge clock);
    #2;
    clear = 1'b1;
    in_reset = 0;
  endtask

  // Monitor: compares the DUT state each cycle and pops on handshakes.
  always @(negedge clock) begin
    logic [DW-1:0] e;
    if (!in_reset && clear) begin
      chk("count", 64'(count), 64'(mdl_cnt));
      chk("empty", 64'(empty), 64'(mdl_cnt == 0));
      chk("full", 64'(full), 64'(mdl_cnt == DEPTH));
      chk("overflow", 64'(overflow), 64'(mdl_ovf));
      chk("valid", 64'(dev_if.dev_valid), 64'(mdl_cnt != 0));
      if (prev_hold) begin
        chk("hold_valid", 64'(dev_if.dev_valid), 64'd1);
        chk("hold_data", 64'(dev_if.dev_data), 64'(prev_data));
      end
      if (!dev_if.dev_valid) begin
        chk("idle_data", 64'(dev_if.dev_data), 64'd0);
`ifdef OUT_PORT_PARITY_EN
        chk("idle_parity", 64'(dev_if.dev_parity), 64'd0);
`endif
      end else if (exp_q.size() > 0) begin
        chk("head_data", 64'(dev_if.dev_data), 64'(exp_q[0]));
`ifdef OUT_PORT_PARITY_EN
        chk("head_parity", 64'(dev_if.dev_parity), 64'(^exp_q[0]));
`endif
      end
      if (dev_if.dev_valid && dev_if.dev_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_model_empty", 64'(dev_if.dev_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 64'(dev_if.dev_data), 64'(e));
        end
      end
      prev_hold = dev_if.dev_valid && !dev_if.dev_ready;
      prev_data = dev_if.dev_data;
    end else begin
      prev_hold = 0;
    end
  end

  logic [DW-1:0] fill_v [4];

  initial begin
    fill_v[0] = 32'h11;
    fill_v[1] = 32'h22;
    fill_v[2] = 32'h33;
    fill_v[3] = 32'h44;
    dev_if.dev_ready = 1'b0;
    clear = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("init_valid", 64'(dev_if.dev_valid), 64'd0);
    chk("init_count", 64'(count), 64'd0);
    clear = 1'b1;
    in_reset = 0;

    // single word held, then accepted
    step(1, 32'h0000_00A5, 0);
    repeat (5) step(0, '0, 0);
    step(0, '0, 1);
    step(0, '0, 0);
    step(0, '0, 0);

    // fill, overflow, full push+pop, drain
    for (int i = 0; i < 4; i++) step(1, fill_v[i], 0);
    step(1, 32'h55, 0);
    step(0, '0, 0);
    step(1, 32'h66, 1);
    repeat (6) step(0, '0, 1);

    // plain fill and drain after a reset
    do_reset();
    for (int i = 0; i < 4; i++) step(1, fill_v[i], 0);
    repeat (6) step(0, '0, 1);

    // wrap with back-to-back push/pop
    for (int i = 0; i < 10; i++) step(1, 32'h100 + i, 1);
    repeat (2) step(0, '0, 1);

    // parity pattern
    step(1, 32'h7, 0);
    step(1, 32'h3, 0);
    step(0, '0, 0);
    repeat (3) step(0, '0, 1);

    // reset with words in flight
    for (int i = 0; i < 3; i++) step(1, fill_v[i], 0);
    do_reset();
    step(0, '0, 1);

    // random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(($urandom_range(0, 99) < 55), $urandom, ($urandom_range(0, 99) < 45));
    end
    repeat (DEPTH + 3) step(0, '0, 1);
    @(negedge clock);
    #1;
    chk("drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
